// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: D = A - B - BIN over WIDTH bits, one 4-bit lookahead nibble per clock, LSB first.
// Latency: start sampled at edge E0, done pulses after edge E(NIBS); one operation per NIBS+1 cycles.
// Backpressure: start is ignored while busy; NIBBLE_SUB_OVF_EN adds a two's-complement overflow output.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef NIBBLE_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBS = WIDTH / 4;
    localparam int KW   = (NIBS > 1) ? $clog2(NIBS) : 1;

    // Reject widths that are not a whole number of nibbles.
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
        $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             done_q;

    logic             accept;
    logic             last;
    logic [3:0]       an;
    logic [3:0]       bn;
    logic [3:0]       p;
    logic [3:0]       g;
    logic [4:0]       c;
    logic [3:0]       sum;

    // Operands shift right each step, so the active nibble is always bits [3:0].
    assign accept = (state_q == IDLE) && start;
    assign last   = (k_q == KW'(NIBS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and busy flag.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // 4-bit borrow-lookahead slice: a + ~b + ~borrow with flat carry equations.
    always_comb begin
        an   = a_q[3:0];
        bn   = ~b_q[3:0];
        p    = an ^ bn;
        g    = an & bn;
        c[0] = ~borrow_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
    end

    // Operand capture on start, then one nibble written into d per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            k_q      <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                borrow_q <= bin;
                k_q      <= '0;
                d_q      <= '0;
            end else if (state_q == RUN) begin
                d_q[k_q*4 +: 4] <= sum;
                borrow_q        <= ~c[4];
                a_q             <= a_q >> 4;
                b_q             <= b_q >> 4;
                k_q             <= k_q + KW'(1);
                if (last) begin
                    done_q <= 1'b1;
                    bout_q <= ~c[4];
                end
            end
        end
    end

    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

`ifdef NIBBLE_SUB_OVF_EN
    logic ovf_q;

    // Overflow from the latched operand MSBs (now in bit 3) and the top result bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if ((state_q == RUN) && last) begin
            ovf_q <= (a_q[3] != b_q[3]) && (sum[3] != a_q[3]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Testbench for nibble_serial_subtractor (WIDTH=16).
// Table-driven vectors plus hand sequences for mid-run start, reset abort and back-to-back starts.
// Build with NIBBLE_SUB_OVF_EN defined to also check the overflow output.
module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] d;
    logic        bout;
`ifdef NIBBLE_SUB_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef NIBBLE_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for done, counting negedges from the first negedge after E0.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[7] = '{16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[8] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[9] = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        bin   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_d", {16'd0, d}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
`ifdef NIBBLE_SUB_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Table-driven operations.
        for (int i = 0; i < 10; i++) begin
            a = vecs[i].a; b = vecs[i].b; bin = vecs[i].bin; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            a = ~vecs[i].a; b = ~vecs[i].b; bin = ~vecs[i].bin;
            chk($sformatf("v%0d_busy_run", i), {31'd0, busy}, 32'd1);
            chk($sformatf("v%0d_d_cleared", i), {16'd0, d}, 32'd0);
            wait_done(n);
            chk($sformatf("v%0d_latency", i), n, 4);
            chk($sformatf("v%0d_d", i), {16'd0, d}, {16'd0, vecs[i].d});
            chk($sformatf("v%0d_bout", i), {31'd0, bout}, {31'd0, vecs[i].bout});
            chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd0);
`ifdef NIBBLE_SUB_OVF_EN
            chk($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
`endif
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d_d_hold", i), {16'd0, d}, {16'd0, vecs[i].d});
        end

        // Start asserted mid-run is ignored.
        a = 16'h1000; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midstart_latency", n, 4);
        chk("midstart_d", {16'd0, d}, 32'h0FFF);
        chk("midstart_bout", {31'd0, bout}, 32'd0);
        @(negedge clk);
        chk("midstart_no_requeue", {31'd0, busy}, 32'd0);

        // Reset at E2 aborts the operation.
        a = 16'h1234; b = 16'h0235; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_d", {16'd0, d}, 32'd0);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("abort_no_done", n, 0);
        a = 16'h0010; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("restart_latency", n, 4);
        chk("restart_d", {16'd0, d}, 32'h000F);
        @(negedge clk);

        // Held start: accepted again on the done cycle, no gap.
        a = 16'h0003; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done(n);
        chk("b2b_first_latency", n, 4);
        chk("b2b_first_d", {16'd0, d}, 32'h0002);
        a = 16'h0010; b = 16'h0001;
        @(negedge clk);
        chk("b2b_busy_again", {31'd0, busy}, 32'd1);
        chk("b2b_done_pulse", {31'd0, done}, 32'd0);
        wait_done(n);
        chk("b2b_second_latency", n, 4);
        chk("b2b_second_d", {16'd0, d}, 32'h000F);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle subtractor computing D = A - B - BIN over WIDTH-bit operands, one 4-bit nibble per clock, least significant nibble first.
- Each nibble uses a 4-bit borrow-lookahead slice: invert B and add with carry-in = ~borrow.
- Borrow is registered between nibbles, so area is fixed and independent of WIDTH.
- Sits beside the team's combinational adders as the subtract engine for wide-word datapaths, behind a start/busy/done handshake.

Parameters:
- WIDTH, 16: operand and result width. Must be a multiple of 4 and ≥ 4. Any other value is illegal; elaboration must fail.
- NIBS, WIDTH/4: derived nibble count N. Localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  minuend; captured on accepted start.
- b  in  WIDTH  subtrahend; captured on accepted start.
- bin  in  1  borrow-in; captured on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- d  out  WIDTH  difference; held stable from done until the next accepted start.
- bout  out  1  final borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, d=0, bout=0; internal operand registers, borrow and nibble index cleared.
  - Reset overrides all other inputs.
  - Reset during RUN aborts the operation: no done pulse, and d reads 0.
- States:
  - IDLE: accepts start.
  - RUN: processes nibbles, no other states.
- IDLE to RUN:
  - On the edge where start=1, latch a, b, borrow=bin, index k=0.
  - busy=1 from the following cycle.
- RUN step (one per edge, nibble k):
  - Compute sum = a[4k+3:4k] + ~b[4k+3:4k] + ~borrow using p = a ^ ~b, g = a & ~b and full lookahead carries c1..c4, with c0 = ~borrow. No ripple chain.
  - Write the nibble result into d[4k+3:4k] and set borrow = ~c4.
  - Increment k. Bits of d not yet computed read 0 during RUN.
- RUN to IDLE:
  - On the edge processing nibble N-1: busy goes to 0, done goes to 1 for exactly one cycle, and bout = ~c4 of the last nibble.
- Latency:
  - start sampled at edge E0; done is high after edge E(N). N=4 cycles for WIDTH=16.
  - Throughput is one operation per N+1 cycles, counting the start cycle.
- Handshake:
  - start while busy=1 is ignored, and operand inputs are don't-care.
  - start in the same cycle done=1 is accepted, since the FSM is already in IDLE. The next operation then begins with no gap.
  - Held start restarts back-to-back each time the FSM returns to IDLE.
- Width and wrap rules:
  - d is the result modulo 2^WIDTH.
  - a=b with bin=0 gives d=0, bout=0.
  - a=b with bin=1 gives all-ones, bout=1.
- Input changes on a, b, bin after the accepted start have no effect on the running operation.

Optional Feature:
- Macro: NIBBLE_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - ovf updates on the done edge to the two's-complement overflow of the operation: (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]). The MSBs used are those of the latched operands.
  - ovf resets to 0 and holds its value until the next done.
- Undefined: port absent; no overflow logic is generated.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0235, bin=0, start one cycle -> busy for 4 cycles; done pulse after edge E4; d=0x0FFF, bout=0.
- a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1.
- a=0x0005, b=0x0005, bin=1 -> d=0xFFFF, bout=1. Same operands with bin=0 -> d=0x0000, bout=0.
- a=0x1000, b=0x0001 (borrow ripples across 3 nibble boundaries) -> d=0x0FFF, bout=0. Then start asserted mid-RUN with a=0xFFFF: ignored, result unchanged.
- Start a=0x1234, b=0x0235; drop rst_n at edge E2 -> no done, busy=0, d=0. Restart with a=0x0010, b=0x0001 -> d=0x000F, done after 4 cycles.
- NIBBLE_SUB_OVF_EN defined:
  - a=0x8000, b=0x0001 -> d=0x7FFF, ovf=1, bout=0.
  - a=0x7FFF, b=0xFFFF -> d=0x8000, ovf=1, bout=1.
  - a=0x0003, b=0x0001 -> ovf=0.
